piso_stream: RTL and testbench

Parametrised parallel-in/serial-out converter between a standard (1-cycle read latency) FIFO holding wide words and a 64-bit-class streaming datapath such as the 10GbE transmit path. Each INPUT_SIZE word read from the FIFO is emitted as RATIO = INPUT_SIZE/OUTPUT_SIZE narrow beats on a valid/ready interface. A one-word holding buffer prefetches the next FIFO word so that back-to-back words stream with no idle cycles under full downstream readiness.

---
 rtl/piso_stream.sv | 74 +++++++
 tb/tb_piso_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// piso_stream: wide FIFO words to narrow valid/ready beats with one-word prefetch; define PISO_LAST_EN for the o_last port
module piso_stream #(
    parameter int INPUT_SIZE  = 256,
    parameter int OUTPUT_SIZE = 64,
    parameter bit MSW_FIRST   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUT_SIZE-1:0]  i_parallel,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    output logic [OUTPUT_SIZE-1:0] o_serial,
    output logic                   o_valid,
    input  logic                   i_ready
`ifdef PISO_LAST_EN
    ,
    output logic                   o_last
`endif
);
    localparam int RATIO = INPUT_SIZE / OUTPUT_SIZE;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if ((INPUT_SIZE % OUTPUT_SIZE) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("piso_stream: INPUT_SIZE must be a multiple of OUTPUT_SIZE with ratio >= 2");
    end

    typedef enum logic [1:0] {EMPTY, RUN, FULL} state_t;

    state_t state, state_nx;
    logic [RATIO-1:0][OUTPUT_SIZE-1:0] sr, hb;
    logic [CW-1:0] cnt, idx;
    logic rp, sr_valid, hb_valid, last_acc, ld_sr_rd, ld_sr_hb, ld_hb;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;

    // Read data lands in SR whenever SR is free by the end of this cycle, else parks in HB
    always_comb begin
        last_acc = sr_valid & i_ready & (cnt == LAST);
        ld_sr_hb = hb_valid & last_acc;
        ld_sr_rd = rp & ~hb_valid & (~sr_valid | last_acc);
        ld_hb    = rp & sr_valid & ~last_acc;
        state_nx = ld_hb ? FULL : (ld_sr_rd | ld_sr_hb) ? RUN : last_acc ? EMPTY : state;
    end

    always_comb begin
        sr_valid = state != EMPTY;
        hb_valid = state == FULL;
        o_valid  = sr_valid;
        fifo_re  = rst_n & ~fifo_empty & ~rp & ~hb_valid;
        idx      = MSW_FIRST ? LAST - cnt : cnt;
        o_serial = sr[idx];
`ifdef PISO_LAST_EN
        o_last   = sr_valid & (cnt == LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rp  <= 1'b0;
            cnt <= '0;
            sr  <= '0;
            hb  <= '0;
        end else begin
            rp <= fifo_re;
            if (ld_hb) hb <= i_parallel;
            if (ld_sr_hb) sr <= hb;
            else if (ld_sr_rd) sr <= i_parallel;
            if (ld_sr_hb | ld_sr_rd | last_acc) cnt <= '0;
            else if (sr_valid & i_ready) cnt <= cnt + CW'(1);
        end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: directed checks of piso_stream (256->64 LSW-first and 128->32 MSW-first)
module tb_piso_stream;
    logic clk = 1'b0, rst_n = 1'b0, i_ready = 1'b1;
    logic [255:0] i_parallel = '0;
    logic [127:0] i_parallel2 = '0;
    logic fifo_empty, fifo_re, o_valid, fifo_empty2, fifo_re2, o_valid2;
    logic [63:0] o_serial;
    logic [31:0] o_serial2;
`ifdef PISO_LAST_EN
    logic o_last, o_last2;
`endif
    int vectors = 0, miscompares = 0;
    int wr = 0, rd = 0, wr2 = 0, rd2 = 0;
    int reads = 0, beats = 0, over = 0, gaps = 0, stall_bad = 0;
    logic [255:0] mem [0:63];
    logic [127:0] mem2 [0:7];
    logic [63:0] exp_q [$];
    logic [15:0] rdy_pat = 16'b1001_0110_1100_1011;

    piso_stream dut (
        .clk(clk), .rst_n(rst_n), .i_parallel(i_parallel), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .o_serial(o_serial), .o_valid(o_valid), .i_ready(i_ready)
`ifdef PISO_LAST_EN
        , .o_last(o_last)
`endif
    );

    piso_stream #(.INPUT_SIZE(128), .OUTPUT_SIZE(32), .MSW_FIRST(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_parallel(i_parallel2), .fifo_empty(fifo_empty2),
        .fifo_re(fifo_re2), .o_serial(o_serial2), .o_valid(o_valid2), .i_ready(i_ready)
`ifdef PISO_LAST_EN
        , .o_last(o_last2)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty  = (wr == rd);
    assign fifo_empty2 = (wr2 == rd2);

    always @(posedge clk) begin
        if (fifo_re) begin
            i_parallel <= mem[rd];
            rd <= rd + 1;
        end
        if (fifo_re2) begin
            i_parallel2 <= mem2[rd2];
            rd2 <= rd2 + 1;
        end
    end

    // Words buffered or in flight may never exceed two
    always @(posedge clk)
        if (!rst_n) begin
            reads = 0;
            beats = 0;
        end else begin
            if (fifo_re && reads - beats / 4 > 1) over++;
            if (fifo_re) reads++;
            if (o_valid && i_ready) beats++;
        end

    function automatic logic [63:0] sl(input int w, input int j);
        return {32'hA5A5_0000 + 32'(w), 32'h5A5A_0000 + 32'(j)};
    endfunction

    function automatic logic [255:0] word(input int w);
        return {sl(w, 3), sl(w, 2), sl(w, 1), sl(w, 0)};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int w, input bit expect_beats);
        mem[wr] = word(w);
        wr++;
        if (expect_beats) for (int j = 0; j < 4; j++) exp_q.push_back(sl(w, j));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int n, input int budget, input bit bp);
        int got = 0, cyc = 0;
        logic [63:0] prev = '0;
        bit stalled = 1'b0, started = 1'b0;
        gaps = 0;
        stall_bad = 0;
        while (got < n && cyc < budget) begin
            i_ready = bp ? rdy_pat[cyc % 16] : 1'b1;
            if (stalled && o_serial !== prev) stall_bad++;
            if (started && !o_valid) gaps++;
            if (o_valid && i_ready) begin
                check(tag, o_serial, exp_q.pop_front());
`ifdef PISO_LAST_EN
                check({tag, "_last"}, o_last, got % 4 == 3);
`endif
                got++;
            end
            started = started | o_valid;
            stalled = o_valid & ~i_ready;
            prev = o_serial;
            tick();
            cyc++;
        end
        i_ready = 1'b1;
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] w0;
        logic [63:0] s;
        logic [31:0] e2 [8];
        int r0, n2, found;
        w0 = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
        mem[wr] = w0;
        wr++;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_re", fifo_re, 0);
        check("rst_serial", o_serial, 0);
`ifdef PISO_LAST_EN
        check("rst_last", o_last, 0);
`endif
        rst_n = 1'b1;
        #1;
        check("lat_re_n", fifo_re, 1);
        tick();
        check("lat_n1_valid", o_valid, 0);
        check("lat_n1_re", fifo_re, 0);
        tick();
        for (int j = 0; j < 4; j++) begin
            s = {16{4'(j)}};
            check("lat_valid", o_valid, 1);
            check("lat_beat", o_serial, s);
`ifdef PISO_LAST_EN
            check("lat_last", o_last, j == 3);
`endif
            tick();
        end
        check("lat_idle", o_valid, 0);

        for (int i = 1; i <= 8; i++) push_word(i, 1'b1);
        r0 = reads;
        drain("stream", 32, 60, 1'b0);
        check("stream_gaps", gaps, 0);
        check("stream_re", reads - r0, 8);

        for (int i = 9; i <= 12; i++) push_word(i, 1'b1);
        drain("bp", 16, 150, 1'b1);
        check("bp_hold", stall_bad, 0);
        for (int i = 13; i <= 15; i++) push_word(i, 1'b1);
        i_ready = 1'b0;
        repeat (6) tick();
        check("hb_full_re", fifo_re, 0);
        check("hb_full_valid", o_valid, 1);
        check("hb_full_hold", o_serial, sl(13, 0));
        drain("hb", 12, 40, 1'b0);
        check("buffer_limit", over, 0);

        push_word(16, 1'b1);
        push_word(17, 1'b1);
        drain("dry", 8, 40, 1'b0);
        check("dry_valid", o_valid, 0);
        repeat (3) tick();
        check("dry_re", fifo_re, 0);
        check("dry_idle", o_valid, 0);
        push_word(18, 1'b1);
        #1;
        check("resume_re", fifo_re, 1);
        drain("resume", 4, 20, 1'b0);

        e2 = '{32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA,
               32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mem2[wr2] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        wr2++;
        mem2[wr2] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        wr2++;
        n2 = 0;
        for (int c = 0; c < 30 && n2 < 8; c++) begin
            if (o_valid2) begin
                check("msw_beat", o_serial2, e2[n2]);
`ifdef PISO_LAST_EN
                check("msw_last", o_last2, n2 % 4 == 3);
`endif
                n2++;
            end
            tick();
        end
        check("msw_count", n2, 8);

        push_word(20, 1'b0);
        push_word(21, 1'b0);
        push_word(22, 1'b1);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (o_valid && o_serial == sl(20, 2)) found = 1;
            else tick();
        end
        check("mid_found", found, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_re", fifo_re, 0);
        check("mid_rst_serial", o_serial, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        drain("post_rst", 4, 20, 1'b0);
        check("final_limit", over, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
